// File: rtl/ror_pkg.sv
// Shared definitions for the ror rotator and its command sequencer.
package ror_pkg;

  localparam logic [1:0] ROR_0 = 2'b00;
  localparam logic [1:0] ROR_1 = 2'b01;
  localparam logic [1:0] ROR_2 = 2'b10;
  localparam logic [1:0] ROR_3 = 2'b11;

  localparam int unsigned ROR_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } ror_state_e;

  typedef struct packed {
    logic [ROR_N-1:0] bits;
    logic [1:0]       amt;
    logic [2:0]       cnt;
  } ror_cmd_t;

endpackage

// File: rtl/ror.sv
// Single-shot combinational rotate-right by 0..3; passes the word through when disabled.
module ror #(
  parameter int unsigned n = 4
) (
  input  logic         en,
  input  logic [1:0]   ctrl,
  input  logic [n-1:0] bits,
  output logic [n-1:0] out
);

  logic [2*n-1:0] dbl;

  always_comb begin
    dbl = {bits, bits} >> ctrl;
    out = en ? dbl[n-1:0] : bits;
  end

endmodule

// File: rtl/ror_cmd_fifo.sv
// Synchronous command FIFO; extra pointer MSB separates full from empty.
module ror_cmd_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage is left uncleared; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ror_cmd_ctrl.sv
// Multi-step rotate engine: buffers commands and iterates the ror rotator cnt times.
module ror_cmd_ctrl
  import ror_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_bits,
  input  logic [1:0]   in_amt,
  input  logic [2:0]   in_cnt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_bits
);

  localparam int unsigned CW = N + 5;

  ror_state_e   state_q, state_d;
  logic [N-1:0] work_q, work_d;
  logic [1:0]   amt_q, amt_d;
  logic [2:0]   cnt_q, cnt_d;

  logic [CW-1:0] fifo_rdata;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [N-1:0]  pop_bits;
  logic [1:0]    pop_amt;
  logic [2:0]    pop_cnt;

  logic          ror_en;
  logic [1:0]    ror_ctrl;
  logic [N-1:0]  ror_bits, ror_out;

  ror_cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i ({in_bits, in_amt, in_cnt}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {pop_bits, pop_amt, pop_cnt} = fifo_rdata;

  ror #(
    .n (N)
  ) u_ror (
    .en   (ror_en),
    .ctrl (ror_ctrl),
    .bits (ror_bits),
    .out  (ror_out)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = (state_q == DONE);
  assign out_bits  = work_q;
  assign ror_en    = (state_q == ROT);
  assign ror_ctrl  = ror_en ? amt_q : ROR_0;
  assign ror_bits  = ror_en ? work_q : '0;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    amt_d    = amt_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          work_d   = pop_bits;
          amt_d    = pop_amt;
          cnt_d    = pop_cnt;
          state_d  = (pop_cnt == 3'd0) ? DONE : ROT;
        end
      end
      ROT: begin
        // cnt is never 0 here: zero-step commands skip straight to DONE.
        work_d = ror_out;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= ROR_0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ror_cmd_ctrl.sv
// Scoreboard bench for ror_cmd_ctrl: directed vectors plus a randomised handshake soak.
module tb_ror_cmd_ctrl;
  import ror_pkg::*;

  localparam int unsigned CLK_HALF = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_bits = '0;
  logic [1:0] in_amt = '0;
  logic [2:0] in_cnt = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_bits;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [3:0]  exp_q[$];
  bit          en_seen = 0;
  bit          valid_seen = 0;
  bit          rnd_done = 0;

  ror_cmd_ctrl #(.N(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .in_amt    (in_amt),
    .in_cnt    (in_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits)
  );

  always #(CLK_HALF) clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Independent reference: rotate right one bit at a time, (amt*cnt) mod 4 times.
  function automatic logic [3:0] model(input logic [3:0] b, input logic [1:0] a, input logic [2:0] c);
    logic [3:0] r = b;
    int unsigned k = (int'(a) * int'(c)) % 4;
    for (int unsigned i = 0; i < k; i++) r = {r[0], r[3:1]};
    return r;
  endfunction

  // Monitor: a transfer happens at the next rising edge when both are high.
  always @(negedge clk) begin
    if (out_valid) valid_seen = 1;
    if (dut.ror_en) en_seen = 1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 32'(out_bits), 32'hdead);
      else chk("out_bits", 32'(out_bits), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #(2 * CLK_HALF * 80000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [3:0] b, input logic [1:0] a, input logic [2:0] c, input logic [3:0] e);
    bit ok = 0;
    in_valid = 1'b1; in_bits = b; in_amt = a; in_cnt = c;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("send_timeout", 32'(0), 32'(1));
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 32'(exp_q.size()), 32'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [3:0] t4_bits [5] = '{4'b0001, 4'b0011, 4'b1000, 4'b0101, 4'b1110};
  logic [1:0] t4_amt  [5] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
  logic [2:0] t4_cnt  [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3};
  logic [3:0] t4_exp  [5] = '{4'b1000, 4'b1100, 4'b0010, 4'b1010, 4'b1011};

  initial begin
    int unsigned acc;
    ror_cmd_t cmd;

    // Reset values
    #(3 * CLK_HALF);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_bits", 32'(out_bits), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // One step, with latency
    send(4'b0001, 2'b01, 3'd1, 4'b1000);
    chk("lat1_e0", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    chk("lat1_e1", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    chk("lat1_e2", 32'(out_valid), 32'(1));
    drain();

    // Multi-step and net-zero rotation
    send(4'b0001, 2'b01, 3'd3, 4'b0010);
    send(4'b1011, 2'b10, 3'd2, 4'b1011);
    send(4'b1101, 2'b00, 3'd5, 4'b1101);
    drain();

    // Zero-step command never enables the rotator
    en_seen = 0;
    send(4'b0110, 2'b01, 3'd0, 4'b0110);
    chk("cnt0_e0", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    chk("cnt0_e1", 32'(out_valid), 32'(1));
    drain();
    chk("cnt0_no_ror_en", 32'(en_seen), 32'(0));

    // Back-pressure fills FIFO plus working register
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_bits = (acc < 5) ? t4_bits[acc] : 4'hF;
      in_amt  = (acc < 5) ? t4_amt[acc] : 2'b01;
      in_cnt  = (acc < 5) ? t4_cnt[acc] : 3'd1;
      @(negedge clk);
      if (in_ready) begin
        if (acc < 5) exp_q.push_back(t4_exp[acc]);
        else exp_q.push_back(4'hF);
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'(5));
    chk("bp_in_ready", 32'(in_ready), 32'(0));
    out_ready = 1'b1;
    drain();

    // Asynchronous reset mid-rotation
    send(4'b1001, 2'b01, 3'd7, 4'b0000);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_out_bits", 32'(out_bits), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    chk("arst_ror_en", 32'(dut.ror_en), 32'(0));
    chk("arst_ror_ctrl", 32'(dut.ror_ctrl), 32'(0));
    chk("arst_ror_bits", 32'(dut.ror_bits), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    valid_seen = 0;
    repeat (12) @(posedge clk);
    #1;
    chk("arst_no_valid", 32'(valid_seen), 32'(0));
    send(4'b0110, 2'b11, 3'd1, 4'b1100);
    drain();

    // Randomised handshake soak
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          cmd.bits = 4'($urandom_range(0, 15));
          cmd.amt  = 2'($urandom_range(0, 3));
          cmd.cnt  = 3'($urandom_range(0, 7));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send(cmd.bits, cmd.amt, cmd.cnt, model(cmd.bits, cmd.amt, cmd.cnt));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
